// File: rtl/i2cmb_cmd_pkg.sv
// rtl/i2cmb_cmd_pkg.sv - shared types, register map and status decode for the I2CMB command engine
package i2cmb_cmd_pkg;

    typedef enum logic [2:0] {
        I2CMB_OP_WAIT     = 3'd0,
        I2CMB_OP_WRITE    = 3'd1,
        I2CMB_OP_READ_ACK = 3'd2,
        I2CMB_OP_READ_NAK = 3'd3,
        I2CMB_OP_START    = 3'd4,
        I2CMB_OP_STOP     = 3'd5,
        I2CMB_OP_SET_BUS  = 3'd6
    } cmd_op_e;

    typedef enum logic [2:0] {
        RSP_DONE     = 3'd0,
        RSP_NAK      = 3'd1,
        RSP_ARB_LOST = 3'd2,
        RSP_ERR      = 3'd3,
        RSP_TIMEOUT  = 3'd4
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_IDLE,
        ST_DPR_WR,
        ST_CMDR_WR,
        ST_WAIT_DONE,
        ST_STAT_RD,
        ST_DATA_RD,
        ST_RSP
    } state_e;

    localparam logic [1:0] CSR_ADDR  = 2'd0;
    localparam logic [1:0] DPR_ADDR  = 2'd1;
    localparam logic [1:0] CMDR_ADDR = 2'd2;

    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    // Arbitration loss dominates, then bus error, then NAK, then plain done.
    function automatic rsp_status_e decode_status(input logic [7:0] cmdr);
        if (cmdr[CMDR_AL])       return RSP_ARB_LOST;
        else if (cmdr[CMDR_ERR]) return RSP_ERR;
        else if (cmdr[CMDR_NAK]) return RSP_NAK;
        else                     return RSP_DONE;
    endfunction

    function automatic logic op_uses_dpr(input logic [2:0] op);
        return (op == I2CMB_OP_WAIT) || (op == I2CMB_OP_WRITE) || (op == I2CMB_OP_SET_BUS);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == I2CMB_OP_READ_ACK) || (op == I2CMB_OP_READ_NAK);
    endfunction

endpackage

// File: rtl/i2cmb_wb_master_port.sv
// rtl/i2cmb_wb_master_port.sv - single-access Wishbone master handshake with registered bus outputs
module i2cmb_wb_master_port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [1:0] adr,
    input  logic [7:0] dat,
    output logic       done,
    output logic [7:0] rdata,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [1:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    // The ack edge drops the bus, so a held req naturally leaves one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 2'd0;
            wb_dat_o <= 8'd0;
        end else if (wb_cyc_o && wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 2'd0;
            wb_dat_o <= 8'd0;
        end else if (req && !wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
        end
    end

    assign done  = wb_cyc_o & wb_ack_i;
    assign rdata = wb_dat_i;

endmodule

// File: rtl/i2cmb_cmd_engine.sv
// rtl/i2cmb_cmd_engine.sv - byte-command to I2CMB register sequencer; I2CMB_CMD_ENGINE_POLL_EN selects CMDR polling instead of irq
import i2cmb_cmd_pkg::*;

module i2cmb_cmd_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  CSR_INIT       = 8'hC0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [2:0] rsp_status_o,
    output logic [7:0] rsp_data_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [1:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,
    input  logic       irq_i
);

`ifdef I2CMB_CMD_ENGINE_POLL_EN
    localparam bit         POLL_MODE = 1'b1;
    localparam logic [7:0] CSR_VALUE = CSR_INIT & 8'hBF;
`else
    localparam bit         POLL_MODE = 1'b0;
    localparam logic [7:0] CSR_VALUE = CSR_INIT;
`endif
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    state_e      state, state_next;
    logic [2:0]  op_q;
    logic [7:0]  data_q;
    logic [15:0] wdog, wdog_inc;
    logic        port_req, port_we, port_done;
    logic [1:0]  port_adr;
    logic [7:0]  port_dat, port_rdata;
    logic        accept, rsp_take, complete, timed_out;
    rsp_status_e status_dec;

    assign accept     = cmd_ready_o & cmd_valid_i;
    assign rsp_take   = rsp_valid_o & rsp_ready_i;
    assign wdog_inc   = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
    assign timed_out  = (wdog_inc >= TO_LIM);
    assign complete   = |port_rdata[7:4];
    assign status_dec = decode_status(port_rdata);

    i2cmb_wb_master_port u_port (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .req      (port_req),
        .we       (port_we),
        .adr      (port_adr),
        .dat      (port_dat),
        .done     (port_done),
        .rdata    (port_rdata),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_INIT_WR;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        port_req   = 1'b0;
        port_we    = 1'b0;
        port_adr   = CSR_ADDR;
        port_dat   = 8'd0;
        case (state)
            ST_INIT_WR: begin
                port_req = 1'b1;
                port_we  = 1'b1;
                port_dat = CSR_VALUE;
                if (port_done) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) state_next = op_uses_dpr(cmd_op_i) ? ST_DPR_WR : ST_CMDR_WR;
            end
            ST_DPR_WR: begin
                port_req = 1'b1;
                port_we  = 1'b1;
                port_adr = DPR_ADDR;
                port_dat = data_q;
                if (port_done) state_next = ST_CMDR_WR;
            end
            ST_CMDR_WR: begin
                port_req = 1'b1;
                port_we  = 1'b1;
                port_adr = CMDR_ADDR;
                port_dat = {5'b0, op_q};
                if (port_done) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (POLL_MODE || irq_i) state_next = ST_STAT_RD;
                else if (timed_out)     state_next = ST_RSP;
            end
            ST_STAT_RD: begin
                port_req = 1'b1;
                port_adr = CMDR_ADDR;
                if (port_done) begin
                    if (!complete) begin
                        if (!POLL_MODE)     state_next = ST_WAIT_DONE;
                        else if (timed_out) state_next = ST_RSP;
                    end else if (op_is_read(op_q) && status_dec == RSP_DONE) begin
                        state_next = ST_DATA_RD;
                    end else begin
                        state_next = ST_RSP;
                    end
                end
            end
            ST_DATA_RD: begin
                port_req = 1'b1;
                port_adr = DPR_ADDR;
                if (port_done) state_next = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_take) state_next = ST_IDLE;
            end
            default: state_next = ST_INIT_WR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q         <= 3'd0;
            data_q       <= 8'd0;
            wdog         <= 16'd0;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= 3'd0;
            rsp_data_o   <= 8'd0;
        end else begin
            cmd_ready_o <= (state == ST_IDLE) && !accept;
            if (accept) begin
                op_q         <= cmd_op_i;
                data_q       <= cmd_data_i;
                rsp_status_o <= RSP_DONE;
                rsp_data_o   <= 8'd0;
            end
            // Polling keeps counting through the CMDR reads; irq mode counts only while waiting.
            if (state == ST_CMDR_WR)
                wdog <= 16'd0;
            else if (state == ST_WAIT_DONE || (POLL_MODE && state == ST_STAT_RD))
                wdog <= wdog_inc;
            if (state == ST_WAIT_DONE && state_next == ST_RSP)
                rsp_status_o <= RSP_TIMEOUT;
            if (state == ST_STAT_RD && state_next == ST_RSP)
                rsp_status_o <= complete ? status_dec : RSP_TIMEOUT;
            if (state == ST_DATA_RD && port_done)
                rsp_data_o <= port_rdata;
            if (rsp_take)
                rsp_valid_o <= 1'b0;
            else if (state == ST_RSP)
                rsp_valid_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2cmb_cmd_engine.sv
// tb/tb_i2cmb_cmd_engine.sv - directed bench for i2cmb_cmd_engine against a zero-wait I2CMB register model
module tb_i2cmb_cmd_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [2:0] rsp_status;
    logic [7:0] rsp_data;
    logic       wb_cyc, wb_stb, wb_we, wb_ack;
    logic [1:0] wb_adr;
    logic [7:0] wb_dat_w, wb_dat_r;
    logic       irq;
    logic [7:0] slv_cmdr, slv_dpr;

    always #5 clk = ~clk;

    i2cmb_cmd_engine #(.TIMEOUT_CYCLES(16), .CSR_INIT(8'hC0)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_data_i   (cmd_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_status_o (rsp_status),
        .rsp_data_o   (rsp_data),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_adr_o     (wb_adr),
        .wb_dat_o     (wb_dat_w),
        .wb_dat_i     (wb_dat_r),
        .wb_ack_i     (wb_ack),
        .irq_i        (irq)
    );

    assign wb_ack   = wb_cyc & wb_stb;
    assign wb_dat_r = (wb_adr == 2'd2) ? slv_cmdr : (wb_adr == 2'd1) ? slv_dpr : 8'h00;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc_cnt = 0;
    int unsigned cmdr_wr_edge = 0;
    logic [10:0] wb_log[$];

    // Each completed access is logged as {we, adr, data-on-bus}.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (wb_cyc && wb_stb && wb_ack) begin
            wb_log.push_back({wb_we, wb_adr, wb_we ? wb_dat_w : wb_dat_r});
            if (wb_we && wb_adr == 2'd2) cmdr_wr_edge <= cyc_cnt + 1;
        end
    end

    function automatic logic [10:0] log_at(input int idx);
        return (idx < wb_log.size()) ? wb_log[idx] : 11'h7FF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] d, output int unsigned h);
        wait_cmd_ready();
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk); #1;
        h = cyc_cnt;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_rsp(input int unsigned h, output int unsigned lat);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        lat = cyc_cnt - h;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_lag", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("cmd_ready_rise", 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] cmdr;
        logic [7:0] dpr;
        logic [2:0] exp_status;
        logic [7:0] exp_data;
        bit         dpr_wr;
        bit         data_rd;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int unsigned h, lat, e;
        int          base, n;
        bit          saw_valid;
        logic [10:0] exp_q[$];

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
        rsp_ready = 1'b0; irq = 1'b0; slv_cmdr = 8'h00; slv_dpr = 8'h00;

        //           op    data   cmdr   dpr    st    data   dw rd lat
        vecs[0] = '{3'd1, 8'hA5, 8'h80, 8'h00, 3'd0, 8'h00, 1, 0, 8};
        vecs[1] = '{3'd2, 8'h00, 8'h80, 8'h3C, 3'd0, 8'h3C, 0, 1, 8};
        vecs[2] = '{3'd1, 8'h5A, 8'h40, 8'h00, 3'd1, 8'h00, 1, 0, 8};
        vecs[3] = '{3'd3, 8'h00, 8'hE0, 8'h77, 3'd2, 8'h00, 0, 0, 6};
        vecs[4] = '{3'd4, 8'h00, 8'h90, 8'h00, 3'd3, 8'h00, 0, 0, 6};
        vecs[5] = '{3'd5, 8'h00, 8'h80, 8'h00, 3'd0, 8'h00, 0, 0, 6};
        vecs[6] = '{3'd6, 8'h07, 8'hC0, 8'h00, 3'd1, 8'h00, 1, 0, 8};
        vecs[7] = '{3'd0, 8'h0A, 8'h80, 8'h00, 3'd0, 8'h00, 1, 0, 8};
        vecs[8] = '{3'd3, 8'h00, 8'h80, 8'hFF, 3'd0, 8'hFF, 0, 1, 8};
        vecs[9] = '{3'd2, 8'h00, 8'h50, 8'h99, 3'd3, 8'h00, 0, 0, 6};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, cmd_ready,
                                   rsp_valid, rsp_status, rsp_data}), 32'd0);

        base = wb_log.size();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        wait_cmd_ready();
        check("init_ready", 32'(cmd_ready), 32'd1);
        check("init_count", 32'(wb_log.size() - base), 32'd1);
        check("init_csr_write", 32'(log_at(base)), 32'({1'b1, 2'd0, 8'hC0}));

        irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            slv_cmdr = vecs[i].cmdr;
            slv_dpr  = vecs[i].dpr;
            base     = wb_log.size();
            send_cmd(vecs[i].op, vecs[i].data, h);
            wait_rsp(h, lat);
            check($sformatf("v%0d_status", i), 32'(rsp_status), 32'(vecs[i].exp_status));
            check($sformatf("v%0d_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold", i), 32'({rsp_valid, rsp_status, rsp_data}),
                  32'({1'b1, vecs[i].exp_status, vecs[i].exp_data}));
            exp_q.delete();
            if (vecs[i].dpr_wr) exp_q.push_back({1'b1, 2'd1, vecs[i].data});
            exp_q.push_back({1'b1, 2'd2, 5'b0, vecs[i].op});
            exp_q.push_back({1'b0, 2'd2, vecs[i].cmdr});
            if (vecs[i].data_rd) exp_q.push_back({1'b0, 2'd1, vecs[i].dpr});
            check($sformatf("v%0d_access_count", i), 32'(wb_log.size() - base), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size(); k++)
                check($sformatf("v%0d_access%0d", i, k), 32'(log_at(base + k)), 32'(exp_q[k]));
            consume();
        end

        // CMDR reads back no completion bits twice before DON appears; rsp_ready held high.
        slv_cmdr  = 8'h00;
        base      = wb_log.size();
        rsp_ready = 1'b1;
        send_cmd(3'd1, 8'h22, h);
        n = 0;
        while (wb_log.size() - base < 4 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("poll_two_reads", 32'(wb_log.size() - base), 32'd4);
        slv_cmdr = 8'h80;
        wait_rsp(h, lat);
        check("poll_status", 32'(rsp_status), 32'd0);
        check("poll_access_count", 32'(wb_log.size() - base), 32'd5);
        check("poll_last_read", 32'(log_at(base + 4)), 32'({1'b0, 2'd2, 8'h80}));
        consume();

        // irq never arrives: TIMEOUT must appear 16 cycles after WAIT_DONE entry.
        irq      = 1'b0;
        slv_cmdr = 8'h80;
        base     = wb_log.size();
        send_cmd(3'd4, 8'h00, h);
        n = 0;
        while (cmdr_wr_edge <= h && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("timeout_cmdr_written", 32'(cmdr_wr_edge > h), 32'd1);
        e = cmdr_wr_edge;
        n = 0;
        while (cyc_cnt < e + 15 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("timeout_not_early", 32'(rsp_status), 32'd0);
        @(posedge clk); #1;
        check("timeout_status", 32'(rsp_status), 32'd4);
        wait_rsp(h, lat);
        check("timeout_data", 32'(rsp_data), 32'd0);
        check("timeout_no_reads", 32'(wb_log.size() - base), 32'd1);
        consume();

        // Reset asserted while the CMDR write is on the bus.
        irq = 1'b1;
        send_cmd(3'd1, 8'h11, h);
        n = 0;
        while (!(wb_cyc && wb_adr == 2'd2) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("rst_cmdr_on_bus", 32'({wb_cyc, wb_adr}), 32'({1'b1, 2'd2}));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 32'({wb_cyc, wb_stb, cmd_ready, rsp_valid}), 32'd0);
        base = wb_log.size();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        saw_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
            if (rsp_valid) saw_valid = 1'b1;
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("rst_ready_again", 32'(cmd_ready), 32'd1);
        check("rst_no_response", 32'(saw_valid), 32'd0);
        check("rst_init_count", 32'(wb_log.size() - base), 32'd1);
        check("rst_init_csr_write", 32'(log_at(base)), 32'({1'b1, 2'd0, 8'hC0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
